adder64_pipe: RTL and testbench

//  Pipelined unsigned adder: DATA_WIDTH-bit A + B -> (DATA_WIDTH+1)-bit sum incl. carry-out.

---
 rtl/adder64_pkg.sv | 13 +
 rtl/adder64_slice.sv | 16 +
 rtl/adder64_pipe.sv | 128 ++++++++++++
 tb/tb_adder64_pipe.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/adder64_pkg.sv
// Shared constants for the pipelined adder: default operand/slice widths and stage count.
package adder64_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int STG_WITCH_DEF  = 16;

    function automatic int nstg(input int data_width, input int stg_witch);
        return data_width / stg_witch;
    endfunction

    localparam int NSTG_DEF = nstg(DATA_WIDTH_DEF, STG_WITCH_DEF);

endpackage

// File: rtl/adder64_slice.sv
// One carry-chain slice of the pipelined adder: purely combinational W-bit add with carry in/out.
module adder64_slice
    import adder64_pkg::*;
#(
    parameter int W = STG_WITCH_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/adder64_pipe.sv
// Pipelined unsigned adder, one register stage per STG_WITCH-bit slice; latency NSTG cycles.
// Build option ADDER64_HOLD_EN: stage data registers load only when that stage carries a valid.
module adder64_pipe
    import adder64_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int STG_WITCH  = STG_WITCH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] adda,
    input  logic [DATA_WIDTH-1:0] addb,
    output logic [DATA_WIDTH:0]   result,
    output logic                  o_en
);

    localparam int NSTG = nstg(DATA_WIDTH, STG_WITCH);
    localparam int W    = STG_WITCH;

    logic [NSTG-1:0]       v_q;
    logic [NSTG-1:0]       ld;
    logic [NSTG-1:0]       c_w;
    logic [DATA_WIDTH-1:0] sum_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q[0] <= i_en;
            for (int s = 1; s < NSTG; s++) begin
                v_q[s] <= v_q[s-1];
            end
        end
    end

    // ld[s] is the load enable of every register that lives in stage s.
    always_comb begin
`ifdef ADDER64_HOLD_EN
        ld    = '0;
        ld[0] = i_en;
        for (int s = 1; s < NSTG; s++) begin
            ld[s] = v_q[s-1];
        end
`else
        ld = '1;
`endif
    end

    for (genvar j = 0; j < NSTG; j++) begin : g_stg
        logic [W-1:0] a_op;
        logic [W-1:0] b_op;
        logic [W-1:0] s_d;
        logic         cin;
        logic         cout_d;
        logic         c_q;
        logic [W-1:0] s_dly_q [NSTG-j];

        if (j == 0) begin : g_first
            assign a_op = adda[W-1:0];
            assign b_op = addb[W-1:0];
            assign cin  = 1'b0;
        end else begin : g_skew
            // Operand slice j waits j cycles so it meets the carry from slice j-1.
            logic [W-1:0] a_dly_q [j];
            logic [W-1:0] b_dly_q [j];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int m = 0; m < j; m++) begin
                        a_dly_q[m] <= '0;
                        b_dly_q[m] <= '0;
                    end
                end else begin
                    if (ld[0]) begin
                        a_dly_q[0] <= adda[j*W +: W];
                        b_dly_q[0] <= addb[j*W +: W];
                    end
                    for (int m = 1; m < j; m++) begin
                        if (ld[m]) begin
                            a_dly_q[m] <= a_dly_q[m-1];
                            b_dly_q[m] <= b_dly_q[m-1];
                        end
                    end
                end
            end

            assign a_op = a_dly_q[j-1];
            assign b_op = b_dly_q[j-1];
            assign cin  = c_w[j-1];
        end

        adder64_slice #(.W(W)) u_slice (
            .a    (a_op),
            .b    (b_op),
            .cin  (cin),
            .sum  (s_d),
            .cout (cout_d)
        );

        // Slice sum then rides a deskew line so all slices reach the output together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                c_q <= 1'b0;
                for (int m = 0; m < NSTG - j; m++) begin
                    s_dly_q[m] <= '0;
                end
            end else begin
                if (ld[j]) begin
                    c_q        <= cout_d;
                    s_dly_q[0] <= s_d;
                end
                for (int m = 1; m < NSTG - j; m++) begin
                    if (ld[j+m]) begin
                        s_dly_q[m] <= s_dly_q[m-1];
                    end
                end
            end
        end

        assign c_w[j]          = c_q;
        assign sum_w[j*W +: W] = s_dly_q[NSTG-j-1];
    end

    assign result = {c_w[NSTG-1], sum_w};
    assign o_en   = v_q[NSTG-1];

endmodule

// File: tb/tb_adder64_pipe.sv
// Self-checking bench for adder64_pipe at default widths (64-bit operands, 4 stages).
module tb_adder64_pipe;

    localparam int DW   = 64;
    localparam int NSTG = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_en;
    logic [DW-1:0] adda;
    logic [DW-1:0] addb;
    logic [DW:0]   result;
    logic          o_en;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW:0] exp_q[$];
    logic        vld_q[$];

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW:0]   s;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    adder64_pipe dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (i_en),
        .adda   (adda),
        .addb   (addb),
        .result (result),
        .o_en   (o_en)
    );

    task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [DW-1:0] a, input logic [DW-1:0] b);
        i_en = en;
        adda = a;
        addb = b;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one cycle, then compare the entry that is now NSTG cycles old.
    task automatic tick(input logic en, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW:0] exp, input string tag);
        logic [DW:0] e;
        logic        v;
        drive(en, a, b);
        exp_q.push_back(exp);
        vld_q.push_back(en);
        step();
        if (exp_q.size() == NSTG) begin
            e = exp_q.pop_front();
            v = vld_q.pop_front();
            check({tag, "_oen"}, {{DW{1'b0}}, o_en}, {{DW{1'b0}}, v});
            if (v) check({tag, "_sum"}, result, e);
        end
    endtask

    task automatic rand_tick(input string tag);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        tick(1'b1, a, b, {1'b0, a} + {1'b0, b}, tag);
    endtask

    initial begin
        vecs[0] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 65'h0_0000_0000_0000_0003};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE};
        vecs[2] = '{64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 65'h0_0000_0000_0001_0000};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 65'h1_0000_0000_0000_0000};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65'h1_0000_0000_0000_0000};
        vecs[5] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 65'h0_0000_0001_0000_0000};
        vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 65'h0_2222_2222_2222_2211};

        // Asynchronous reset visible before any clock edge.
        rst_n = 1'b0;
        drive(1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        #2;
        check("rst_result", result, '0);
        check("rst_oen", {{DW{1'b0}}, o_en}, '0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_result", result, '0);
        rst_n = 1'b1;

        // Single transaction: exactly NSTG edges of latency, one-cycle o_en pulse.
        drive(1'b1, 64'd1, 64'd2);
        step();
        drive(1'b0, '0, '0);
        check("lat_e1_oen", {{DW{1'b0}}, o_en}, '0);
        step();
        check("lat_e2_oen", {{DW{1'b0}}, o_en}, '0);
        step();
        check("lat_e3_oen", {{DW{1'b0}}, o_en}, '0);
        check("lat_e3_result", result, '0);
        step();
        check("lat_e4_result", result, 65'd3);
        check("lat_e4_oen", {{DW{1'b0}}, o_en}, 65'd1);
        step();
        check("lat_e5_oen", {{DW{1'b0}}, o_en}, '0);

        // Directed boundary vectors, back to back, then flushed.
        foreach (vecs[i]) tick(1'b1, vecs[i].a, vecs[i].b, vecs[i].s, $sformatf("dir%0d", i));
        for (int i = 0; i < NSTG; i++) tick(1'b0, '0, '0, '0, "dir_flush");

        // 500 random pairs, one per cycle.
        for (int i = 0; i < 500; i++) rand_tick("rnd");
        for (int i = 0; i < NSTG; i++) tick(1'b0, '0, '0, '0, "rnd_flush");

        // Reset mid-stream: outputs clear at once, pipeline refills from zero.
        for (int i = 0; i < 10; i++) rand_tick("pre_rst");
        rst_n = 1'b0;
        #1;
        check("mid_rst_result", result, '0);
        check("mid_rst_oen", {{DW{1'b0}}, o_en}, '0);
        exp_q.delete();
        vld_q.delete();
        @(negedge clk);
        check("mid_rst_hold", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_e0", result, '0);
        for (int i = 0; i < NSTG - 1; i++) begin
            rand_tick("post_rst_fill");
            check($sformatf("post_rst_e%0d", i + 1), result, '0);
        end
        for (int i = 0; i < 20; i++) rand_tick("post_rst");
        for (int i = 0; i < NSTG; i++) tick(1'b0, '0, '0, '0, "post_flush");
        check("idle_oen", {{DW{1'b0}}, o_en}, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
